// File: rtl/paddle_ctrl.sv
// Paddle X position controller: turns left/right button levels into a clamped,
// accelerating paddle position, updated on a programmable move tick.
module paddle_ctrl #(
   parameter int X_W         = 9,
   parameter int SCREEN_W    = 320,
   parameter int PADDLE_W    = 40,
   parameter int X_RESET     = 140,
   parameter int TICK_DIV    = 4,
   parameter int MAX_SPEED   = 4,
   parameter int ACCEL_TICKS = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           left,
   input  logic                           right,
   input  logic                           recentre,
   input  logic                           enable,
   output logic [X_W-1:0]                 x_left,
   output logic [X_W-1:0]                 x_right,
   output logic [$clog2(MAX_SPEED+1)-1:0] speed,
   output logic                           moving,
   output logic                           at_left_edge,
   output logic                           at_right_edge
);

   localparam int SPD_W  = $clog2(MAX_SPEED + 1);
   localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

   localparam logic [X_W:0]       XMAX     = (X_W+1)'(SCREEN_W - PADDLE_W);
   localparam logic [X_W:0]       XRST     = (X_W+1)'(X_RESET);
   localparam logic [SPD_W-1:0]   SPD_ONE  = SPD_W'(1);
   localparam logic [SPD_W-1:0]   SPD_MAX  = SPD_W'(MAX_SPEED);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);

   if ((X_RESET > SCREEN_W - PADDLE_W) || (SCREEN_W >= (1 << X_W))) begin : g_bad_cfg
      $error("paddle_ctrl: X_RESET must fit the playfield and SCREEN_W must fit X_W bits");
   end

   typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   tick_cnt, cnt_n;
   logic [HOLD_W-1:0]  hold, hold_n, hold_inc;
   logic [SPD_W-1:0]   spd_n, mv_spd;
   logic [X_W:0]       x_ext, x_n;
   logic               tick, dir_l, dir_r, same;

   always_comb begin
      dir_l    = left & ~right;
      dir_r    = right & ~left;
      tick     = enable && (tick_cnt == CNT_LAST);
      same     = ((state == MOVE_L) && dir_l) || ((state == MOVE_R) && dir_r);
      x_ext    = {1'b0, x_left};
      hold_inc = hold + HOLD_W'(1);
      state_n  = state;
      spd_n    = speed;
      hold_n   = hold;
      x_n      = x_ext;
      mv_spd   = SPD_ONE;
      cnt_n    = tick_cnt;

      if (enable) cnt_n = tick ? '0 : tick_cnt + CNT_W'(1);

      if (tick) begin
         if (!dir_l && !dir_r) begin
            state_n = IDLE;
            spd_n   = SPD_ONE;
            hold_n  = '0;
         end else begin
            // A fresh direction (from IDLE or a reversal) always moves at speed 1.
            if (same) begin
               mv_spd = speed;
               if (int'(hold_inc) >= ACCEL_TICKS - 1) begin
                  hold_n = '0;
                  spd_n  = (speed == SPD_MAX) ? speed : speed + SPD_ONE;
               end else begin
                  hold_n = hold_inc;
               end
            end else begin
               state_n = dir_l ? MOVE_L : MOVE_R;
               spd_n   = SPD_ONE;
               hold_n  = '0;
            end

            if (dir_l) x_n = (x_ext < (X_W+1)'(mv_spd)) ? '0 : x_ext - (X_W+1)'(mv_spd);
            else       x_n = (x_ext + (X_W+1)'(mv_spd) > XMAX) ? XMAX : x_ext + (X_W+1)'(mv_spd);

            // Touching a wall drops back to the slowest speed but keeps the direction.
            if ((dir_l && (x_n == '0)) || (dir_r && (x_n == XMAX))) begin
               spd_n  = SPD_ONE;
               hold_n = '0;
            end
         end
      end

      if (recentre) begin
         state_n = IDLE;
         x_n     = XRST;
         spd_n   = SPD_ONE;
         hold_n  = '0;
         cnt_n   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         hold          <= '0;
         speed         <= SPD_ONE;
         x_left        <= XRST[X_W-1:0];
         x_right       <= X_W'(X_RESET + PADDLE_W - 1);
         moving        <= 1'b0;
         at_left_edge  <= (X_RESET == 0);
         at_right_edge <= (X_RESET == SCREEN_W - PADDLE_W);
      end else begin
         state         <= state_n;
         tick_cnt      <= cnt_n;
         hold          <= hold_n;
         speed         <= spd_n;
         x_left        <= x_n[X_W-1:0];
         x_right       <= x_n[X_W-1:0] + X_W'(PADDLE_W - 1);
         moving        <= (state_n != IDLE);
         at_left_edge  <= (x_n == '0);
         at_right_edge <= (x_n == XMAX);
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: reset, table of per-tick vectors, corner sequences and
// randomized button traffic against a per-edge arithmetic model.
module tb_paddle_ctrl;

   localparam int X_W         = 9;
   localparam int SCREEN_W    = 320;
   localparam int PADDLE_W    = 40;
   localparam int X_RESET     = 140;
   localparam int TICK_DIV    = 4;
   localparam int MAX_SPEED   = 4;
   localparam int ACCEL_TICKS = 8;
   localparam int XMAX        = SCREEN_W - PADDLE_W;

   logic           clk = 1'b0;
   logic           reset, left, right, recentre, enable;
   logic [X_W-1:0] x_left, x_right;
   logic [2:0]     speed;
   logic           moving, at_left_edge, at_right_edge;

   always #5 clk = ~clk;

   paddle_ctrl #(
      .X_W(X_W), .SCREEN_W(SCREEN_W), .PADDLE_W(PADDLE_W), .X_RESET(X_RESET),
      .TICK_DIV(TICK_DIV), .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
   ) dut (
      .clk(clk), .reset(reset), .left(left), .right(right), .recentre(recentre),
      .enable(enable), .x_left(x_left), .x_right(x_right), .speed(speed),
      .moving(moving), .at_left_edge(at_left_edge), .at_right_edge(at_right_edge)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model: position, speed, continuation ticks since last speed reset,
   // direction (0 none, 1 left, 2 right), phase within the tick period
   int m_x, m_spd, m_since, m_dir, m_phase;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = X_RESET; m_spd = 1; m_since = 0; m_dir = 0; m_phase = 0;
   endtask

   task automatic model_step(input bit l, input bit r, input bit rc, input bit en);
      int d, step, target;
      if (rc) begin
         model_reset();
         return;
      end
      if (!en) return;
      if (m_phase != TICK_DIV - 1) begin
         m_phase++;
         return;
      end
      m_phase = 0;
      d = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
      if (d == 0) begin
         m_dir = 0; m_spd = 1; m_since = 0;
         return;
      end
      if (d == m_dir) begin
         step = m_spd;
         m_since++;
         if (m_since >= ACCEL_TICKS - 1) begin
            m_since = 0;
            m_spd = (m_spd + 1 > MAX_SPEED) ? MAX_SPEED : m_spd + 1;
         end
      end else begin
         step = 1; m_spd = 1; m_since = 0; m_dir = d;
      end
      target = (d == 1) ? m_x - step : m_x + step;
      if (target <= 0) begin
         target = 0; m_spd = 1; m_since = 0;
      end else if (target >= XMAX) begin
         target = XMAX; m_spd = 1; m_since = 0;
      end
      m_x = target;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".x_left"},  int'(x_left),  m_x);
      check({tag, ".x_right"}, int'(x_right), m_x + PADDLE_W - 1);
      check({tag, ".speed"},   int'(speed),   m_spd);
      check({tag, ".moving"},  int'(moving),  int'(m_dir != 0));
      check({tag, ".ledge"},   int'(at_left_edge),  int'(m_x == 0));
      check({tag, ".redge"},   int'(at_right_edge), int'(m_x == XMAX));
   endtask

   task automatic cycle(input bit l, input bit r, input bit rc, input bit en);
      left = l; right = r; recentre = rc; enable = en;
      model_step(l, r, rc, en);
      @(posedge clk);
      @(negedge clk);
      check_model("model");
   endtask

   task automatic do_tick(input bit l, input bit r);
      repeat (TICK_DIV) cycle(l, r, 1'b0, 1'b1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".x_left"},  int'(x_left),  140);
      check({tag, ".x_right"}, int'(x_right), 179);
      check({tag, ".speed"},   int'(speed),   1);
      check({tag, ".moving"},  int'(moving),  0);
      check({tag, ".ledge"},   int'(at_left_edge),  0);
      check({tag, ".redge"},   int'(at_right_edge), 0);
   endtask

   typedef struct {
      bit l;
      bit r;
      int ex;
      int espd;
      int emov;
   } vec_t;

   vec_t vt[15];

   initial begin
      // accelerate right for 10 ticks, both buttons for 4, then one left tick
      for (int i = 0; i < 10; i++) begin
         vt[i].l = 1'b0; vt[i].r = 1'b1; vt[i].emov = 1;
         vt[i].ex   = (i < 8) ? 141 + i : 148 + 2 * (i - 7);
         vt[i].espd = (i < 7) ? 1 : 2;
      end
      for (int i = 10; i < 14; i++) begin
         vt[i].l = 1'b1; vt[i].r = 1'b1; vt[i].ex = 152; vt[i].espd = 1; vt[i].emov = 0;
      end
      vt[14].l = 1'b1; vt[14].r = 1'b0; vt[14].ex = 151; vt[14].espd = 1; vt[14].emov = 1;

      reset = 1'b1; left = 1'b0; right = 1'b0; recentre = 1'b0; enable = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // table vectors
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 15; i++) begin
         do_tick(vt[i].l, vt[i].r);
         check($sformatf("vec%0d.x_left", i), int'(x_left), vt[i].ex);
         check($sformatf("vec%0d.speed", i),  int'(speed),  vt[i].espd);
         check($sformatf("vec%0d.moving", i), int'(moving), vt[i].emov);
      end

      // reversal from speed 3
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (16) do_tick(1'b0, 1'b1);
      check("rev.pre_x", int'(x_left), 165);
      check("rev.pre_speed", int'(speed), 3);
      do_tick(1'b1, 1'b0);
      check("rev.x", int'(x_left), 164);
      check("rev.speed", int'(speed), 1);

      // asynchronous reset between edges while moving right at speed 3
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (16) do_tick(1'b0, 1'b1);
      check("mid.speed", int'(speed), 3);
      #2 reset = 1'b1;
      #1 check_reset_state("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // left clamp
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (46) do_tick(1'b1, 1'b0);
      check("lclamp.pre_x", int'(x_left), 1);
      check("lclamp.pre_speed", int'(speed), 4);
      do_tick(1'b1, 1'b0);
      check("lclamp.x", int'(x_left), 0);
      check("lclamp.edge", int'(at_left_edge), 1);
      check("lclamp.speed", int'(speed), 1);
      repeat (3) do_tick(1'b1, 1'b0);
      check("lclamp.hold_x", int'(x_left), 0);
      check("lclamp.hold_moving", int'(moving), 1);

      // right clamp
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (46) do_tick(1'b0, 1'b1);
      check("rclamp.pre_x", int'(x_left), 279);
      do_tick(1'b0, 1'b1);
      check("rclamp.x", int'(x_left), 280);
      check("rclamp.xr", int'(x_right), 319);
      check("rclamp.edge", int'(at_right_edge), 1);
      check("rclamp.speed", int'(speed), 1);

      // enable low freezes, recentre still honoured, re-enable tick phase
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) do_tick(1'b1, 1'b0);
      repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("en0.x", int'(x_left), 137);
      check("en0.moving", int'(moving), 1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check("en0.recentre_x", int'(x_left), 140);
      check("en0.recentre_moving", int'(moving), 0);
      repeat (TICK_DIV - 1) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      check("reen.before_tick", int'(x_left), 140);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      check("reen.first_tick", int'(x_left), 141);

      // randomized traffic
      for (int i = 0; i < 1500; ) begin
         int pat, len;
         pat = $urandom_range(0, 3);
         len = $urandom_range(1, 40);
         for (int j = 0; j < len; j++)
            cycle(pat[0], pat[1], $urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0);
         i += len;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
